// File: rtl/johnson_pkg.sv
// Shared types and decode helpers for the Johnson-code receiver.
package johnson_pkg;

   // Widest code word the helpers accept; callers zero-extend into this.
   localparam int JD_MAX_N = 32;

   typedef enum logic {HUNT, LOCKED} jd_state_t;

   // Legal iff the ones run unbroken from the LSB (top bit clear) or from
   // the MSB (top bit set); the latter is checked on the complement.
   function automatic logic johnson_legal(input logic [JD_MAX_N-1:0] code,
                                          input int unsigned        n);
      logic [JD_MAX_N-1:0] mask;
      logic [JD_MAX_N-1:0] c;
      logic [JD_MAX_N-1:0] sh;
      mask = (JD_MAX_N'(1) << n) - JD_MAX_N'(1);
      c    = code & mask;
      sh   = c >> (n - 1);
      if (sh[0]) begin
         c = ~c & mask;
      end
      return (c & (c + JD_MAX_N'(1))) == '0;
   endfunction

   // Position of a legal code in the 2n-step ring; meaningless for illegal codes.
   function automatic int unsigned johnson_index(input logic [JD_MAX_N-1:0] code,
                                                 input int unsigned        n);
      logic [JD_MAX_N-1:0] mask;
      logic [JD_MAX_N-1:0] c;
      logic [JD_MAX_N-1:0] sh;
      int unsigned         p;
      mask = (JD_MAX_N'(1) << n) - JD_MAX_N'(1);
      c    = code & mask;
      sh   = c >> (n - 1);
      p    = $countones(c);
      if (sh[0]) begin
         return (2 * n - p) % (2 * n);
      end
      return p;
   endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample strobe/code in, decoded status out.
interface johnson_decoder_if #(
   parameter int N = 4
) ();
   localparam int CW = $clog2(2 * N);

   logic          en;
   logic [N-1:0]  code;
   logic [CW-1:0] count;
   logic          valid;
   logic          locked;
   logic          step_err;
   logic [7:0]    err_count;

   modport master (
      output en, code,
      input  count, valid, locked, step_err, err_count
   );

   modport slave (
      input  en, code,
      output count, valid, locked, step_err, err_count
   );
endinterface

// File: rtl/johnson_counter.sv
// Free-running Johnson (twisted-ring) counter, the transmit side of the code.
module johnson_counter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [N-1:0] q_o
);
   logic [N-1:0] q_q;

   // Shift left, feeding back the inverted MSB.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= {q_q[N-2:0], ~q_q[N-1]};
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/johnson_decoder.sv
// Decodes a sampled Johnson code word, checks single-step progression and
// tracks lock with a HUNT/LOCKED state machine.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter  int N          = 4,
   parameter  int LOCK_COUNT = 3,
   localparam int CW         = $clog2(2 * N)
) (
   input  logic             clock,
   input  logic             reset,
   johnson_decoder_if.slave bus
);

   logic [CW-1:0]       count_q;
   logic                valid_q;
   logic                have_prev_q;
   jd_state_t           state_q,     state_d;
   logic [3:0]          run_q,       run_d;
   logic                step_err_q,  step_err_d;
   logic [7:0]          err_count_q, err_count_d;

   logic [JD_MAX_N-1:0] code_ext;
   logic                code_legal;
   logic [CW-1:0]       code_idx;
   logic [CW-1:0]       count_succ;
   logic                good_step;
   logic [3:0]          run_inc;

   // Decode the incoming word and compare it with the successor of the last one.
   always_comb begin
      code_ext   = JD_MAX_N'(bus.code);
      code_legal = johnson_legal(code_ext, N);
      code_idx   = CW'(johnson_index(code_ext, N));
      count_succ = (count_q == CW'(2 * N - 1)) ? '0 : count_q + CW'(1);
      good_step  = code_legal && have_prev_q && valid_q && (code_idx == count_succ);
      run_inc    = run_q + 4'd1;
   end

   // Sample register: decoded count, legality and first-sample flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         valid_q     <= 1'b0;
         have_prev_q <= 1'b0;
      end else if (bus.en) begin
         count_q     <= code_idx;
         valid_q     <= code_legal;
         have_prev_q <= 1'b1;
      end
   end

   // Lock FSM state register, with run length, error pulse and error tally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= HUNT;
         run_q       <= '0;
         step_err_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         step_err_q  <= step_err_d;
         err_count_q <= err_count_d;
      end
   end

   // Lock FSM next state: count good steps in HUNT, drop out of LOCKED on any bad sample.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      run_d       = run_q;
      step_err_d  = 1'b0;
      err_count_d = err_count_q;
      if (bus.en) begin
         unique case (state_q)
            HUNT: begin
               if (good_step) begin
                  if (run_inc == 4'(LOCK_COUNT)) begin
                     state_d = LOCKED;
                     run_d   = '0;
                  end else begin
                     run_d = run_inc;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCKED: begin
               if (!good_step) begin
                  state_d     = HUNT;
                  run_d       = '0;
                  step_err_d  = 1'b1;
                  err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
               end
            end
            default: begin
               state_d = HUNT;
               run_d   = '0;
            end
         endcase
      end
   end

   // Lock FSM outputs, all straight from registers.
   always_comb begin
      bus.count     = count_q;
      bus.valid     = valid_q;
      bus.locked    = (state_q == LOCKED);
      bus.step_err  = step_err_q;
      bus.err_count = err_count_q;
   end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (N=4, LOCK_COUNT=3).
module tb_johnson_decoder;

   localparam logic [3:0] LEGAL [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                        4'b1111, 4'b1110, 4'b1100, 4'b1000};

   typedef struct {
      logic [2:0] count;
      logic       cnt_care;
      logic       valid;
      logic       locked;
      logic       step_err;
      logic [7:0] err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       use_cnt;
   logic [3:0] tb_code;
   logic [3:0] cnt_q;

   int vectors     = 0;
   int miscompares = 0;
   exp_t sb[$];

   // Reference model state
   logic [2:0] m_count;
   logic       m_valid, m_have, m_locked, m_step;
   int         m_run;
   int         m_err;

   johnson_decoder_if #(.N(4)) bus ();

   johnson_decoder #(.N(4), .LOCK_COUNT(3)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   johnson_counter #(.N(4)) u_cnt (
      .clk  (clk),
      .rst  (~rst_n),
      .en_i (bus.en & use_cnt),
      .q_o  (cnt_q)
   );

   assign bus.code = use_cnt ? cnt_q : tb_code;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int tb_index(input logic [3:0] c);
      for (int i = 0; i < 8; i++) begin
         if (LEGAL[i] == c) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_count = '0; m_valid = 0; m_have = 0; m_locked = 0; m_step = 0;
      m_run = 0; m_err = 0;
   endtask

   task automatic model_step(input logic e, input logic [3:0] c);
      int   idx;
      logic good;
      m_step = 0;
      if (e) begin
         idx  = tb_index(c);
         good = (idx >= 0) && m_have && m_valid && (idx == (int'(m_count) + 1) % 8);
         if (m_locked) begin
            if (!good) begin
               m_locked = 0;
               m_step   = 1;
               m_run    = 0;
               if (m_err < 255) m_err++;
            end
         end else if (good) begin
            m_run++;
            if (m_run == 3) begin
               m_locked = 1;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
         end
         m_have  = 1;
         m_valid = (idx >= 0);
         if (idx >= 0) m_count = 3'(idx);
      end
   endtask

   // Drive one cycle, predict it, then compare after the edge.
   task automatic apply(input logic e, input logic src_cnt, input logic [3:0] c);
      exp_t x;
      @(negedge clk);
      bus.en  = e;
      use_cnt = src_cnt;
      tb_code = c;
      #1;
      model_step(e, bus.code);
      x.count = m_count; x.cnt_care = m_valid; x.valid = m_valid;
      x.locked = m_locked; x.step_err = m_step; x.err = 8'(m_err);
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         if (x.cnt_care) check("count", 32'(bus.count), 32'(x.count));
         check("valid",     32'(bus.valid),     32'(x.valid));
         check("locked",    32'(bus.locked),    32'(x.locked));
         check("step_err",  32'(bus.step_err),  32'(x.step_err));
         check("err_count", 32'(bus.err_count), 32'(x.err));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},  32'(bus.count),     32'd0);
      check({tag, "_valid"},  32'(bus.valid),     32'd0);
      check({tag, "_locked"}, 32'(bus.locked),    32'd0);
      check({tag, "_step"},   32'(bus.step_err),  32'd0);
      check({tag, "_err"},    32'(bus.err_count), 32'd0);
   endtask

   initial begin
      int p;
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      use_cnt = 1'b0;
      tb_code = '0;
      model_reset();
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1-2: counter drives nine samples, lock at 0111, wrap 7->0 keeps lock
      for (int i = 0; i < 9; i++) apply(1'b1, 1'b1, 4'b0000);
      check("wrap_locked", 32'(bus.locked), 32'd1);

      // 3: illegal code breaks lock, then relock at 1111
      apply(1'b1, 1'b0, 4'b0101);
      apply(1'b1, 1'b0, 4'b0001);
      apply(1'b1, 1'b0, 4'b0011);
      apply(1'b1, 1'b0, 4'b0111);
      apply(1'b1, 1'b0, 4'b1111);

      // 4: advance to count 2, skip to 1111, repeat, relock
      for (int i = 5; i < 11; i++) apply(1'b1, 1'b0, LEGAL[i % 8]);
      apply(1'b1, 1'b0, 4'b1111);
      apply(1'b1, 1'b0, 4'b1111);
      apply(1'b1, 1'b0, 4'b1110);
      apply(1'b1, 1'b0, 4'b1100);
      apply(1'b1, 1'b0, 4'b1000);

      // 5: en low with random code, then resume
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 4'($urandom));
      apply(1'b1, 1'b0, 4'b0000);

      // 6a: break once more (err=3), relock, reset between edges
      apply(1'b1, 1'b0, 4'b0000);
      apply(1'b1, 1'b0, 4'b0001);
      apply(1'b1, 1'b0, 4'b0011);
      apply(1'b1, 1'b0, 4'b0111);
      check("pre_rst_err", 32'(bus.err_count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // 6b: 260 lock/unlock cycles to saturate err_count
      p = 0;
      apply(1'b1, 1'b0, LEGAL[p]);
      for (int n = 0; n < 260; n++) begin
         for (int s = 0; s < 3; s++) begin
            p = (p + 1) % 8;
            apply(1'b1, 1'b0, LEGAL[p]);
         end
         apply(1'b1, 1'b0, LEGAL[p]);
      end
      check("err_sat", 32'(bus.err_count), 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
